// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contains the op and state encodings, the width and the iteration count.
package muldiv_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the {hi,lo} accumulator pair.
// Multiply does shift-add; divide does restoring subtract-compare-shift.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_accHi,
  input  logic [WIDTH-1:0] i_accLo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_accHi,
  output logic [WIDTH-1:0] o_accLo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  assign w_sum   = {1'b0, i_accHi} + (i_accLo[0] ? {1'b0, i_operand} : '0);
  assign w_shift = {i_accHi, i_accLo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_operand};
  // A successful trial subtraction always leaves a remainder below the divisor.
  assign w_fits  = (w_diff[WIDTH+1:WIDTH] == 2'b00);

  always_comb begin
    o_accHi = w_sum[WIDTH:1];
    o_accLo = {w_sum[0], i_accLo[WIDTH-1:1]};
    if (i_div) begin
      if (w_fits) begin
        o_accHi = w_diff[WIDTH-1:0];
        o_accLo = {i_accLo[WIDTH-2:0], 1'b1};
      end else begin
        o_accHi = w_shift[WIDTH-1:0];
        o_accLo = {i_accLo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in the FIX state.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER_COUNT);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER_COUNT - 1);

  state_e             r_state;
  state_e             w_next;
  op_e                r_op;
  logic [WIDTH-1:0]   r_accHi;
  logic [WIDTH-1:0]   r_accLo;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_count;
  logic               r_negLo;
  logic               r_negHi;

  op_e                w_opIn;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic               w_divZero;
  logic [WIDTH-1:0]   w_stepHi;
  logic [WIDTH-1:0]   w_stepLo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;

  assign w_opIn    = op_e'(op);
  assign w_aNeg    = op_is_signed(w_opIn) & a[WIDTH-1];
  assign w_bNeg    = op_is_signed(w_opIn) & b[WIDTH-1];
  assign w_aMag    = w_aNeg ? -a : a;
  assign w_bMag    = w_bNeg ? -b : b;
  assign w_divZero = op_is_div(w_opIn) && (b == '0);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div     (op_is_div(r_op)),
    .i_accHi   (r_accHi),
    .i_accLo   (r_accLo),
    .i_operand (r_divisor),
    .o_accHi   (w_stepHi),
    .o_accLo   (w_stepLo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = w_divZero ? DONE : RUN;
      RUN:  if (r_count == LAST_ITER) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Divide negates quotient and remainder independently; multiply negates the 64-bit product.
  assign w_prod = {r_accHi, r_accLo};
  always_comb begin
    {w_fixHi, w_fixLo} = r_negLo ? -w_prod : w_prod;
    if (op_is_div(r_op)) begin
      w_fixLo = r_negLo ? -r_accLo : r_accLo;
      w_fixHi = r_negHi ? -r_accHi : r_accHi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_MULT;
      r_accHi   <= '0;
      r_accLo   <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_negLo   <= 1'b0;
      r_negHi   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_op      <= w_opIn;
            r_count   <= '0;
            r_accHi   <= '0;
            r_accLo   <= w_aMag;
            r_divisor <= w_bMag;
            r_negLo   <= w_aNeg ^ w_bNeg;
            r_negHi   <= w_aNeg;
            if (w_divZero) begin
              r_hi <= a;
              r_lo <= '1;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        RUN: begin
          r_accHi <= w_stepHi;
          r_accLo <= w_stepLo;
          r_count <= r_count + CW'(1);
        end
        FIX: begin
          r_hi <= w_fixHi;
          r_lo <= w_fixLo;
        end
        default: ;
      endcase
    end
  end

  // DONE is a completion marker, so busy covers only the cycles still computing.
  assign busy = (r_state == RUN) || (r_state == FIX);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected results.
// Each scenario task drives its stimulus and compares outputs inline.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Counts edges inclusively: the accepting edge is edge 1; -1 means no done seen.
  task automatic runOp(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       output int edges);
    bit seen;
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    if (!seen) edges = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int e;
    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
    checks++; if (e !== 34) begin failures++; $display("[TB] FAIL multu_latency: got %0d expected 34", e); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin failures++; $display("[TB] FAIL multu_lo: got %h expected 00000001", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_with_done: got %b expected 0", busy); end
  endtask

  task automatic test_signed();
    int e;
    runOp(2'b00, 32'hFFFF_FFFD, 32'd7, e);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("[TB] FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
    runOp(2'b00, 32'h8000_0000, 32'h8000_0000, e);
    checks++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin failures++; $display("[TB] FAIL mult_minmin: got %h_%h expected 40000000_00000000", hi, lo); end
    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, e);
    checks++; if (e !== 34) begin failures++; $display("[TB] FAIL div_latency: got %0d expected 34", e); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("[TB] FAIL div_neg_q: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_neg_r: got %h expected ffffffff", hi); end
    runOp(2'b10, 32'd7, 32'hFFFF_FFFE, e);
    checks++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin failures++; $display("[TB] FAIL div_negdivisor: got %h_%h expected 00000001_fffffffd", hi, lo); end
    runOp(2'b11, 32'd100, 32'd7, e);
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin failures++; $display("[TB] FAIL divu_100_7: got %h_%h expected 00000002_0000000e", hi, lo); end
    runOp(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, e);
    checks++; if ({hi, lo} !== {32'h0000_FFFF, 32'h0000_FFFF}) begin failures++; $display("[TB] FAIL divu_big: got %h_%h expected 0000ffff_0000ffff", hi, lo); end
  endtask

  task automatic test_div_zero();
    int e;
    runOp(2'b11, 32'd100, 32'd0, e);
    checks++; if (e !== 1) begin failures++; $display("[TB] FAIL divzero_latency: got %0d expected 1", e); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL divzero_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h0000_0064) begin failures++; $display("[TB] FAIL divzero_hi: got %h expected 00000064", hi); end
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, e);
    checks++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin failures++; $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", hi, lo); end
  endtask

  task automatic test_latch_and_ignore();
    int edges;
    bit seen;
    @(negedge clk);
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = 1;
    repeat (4) begin @(posedge clk); edges++; end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_midrun: got %b expected 1", busy); end
    op = 2'b11; a = 32'd100; b = 32'd100; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    edges++;
    #1 start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'h0) begin failures++; $display("[TB] FAIL hi_we_busy: got %h expected 00000000", hi); end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin @(posedge clk); edges++; end
    end
    checks++; if (!seen || edges !== 34) begin failures++; $display("[TB] FAIL latch_latency: got %0d expected 34", seen ? edges : -1); end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin failures++; $display("[TB] FAIL latch_result: got %h_%h expected 00000000_0000002a", hi, lo); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL start_not_queued: got busy=%b expected 0", busy); end
  endtask

  task automatic test_writes();
    int e;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    checks++; if (hi !== 32'h0000_1234) begin failures++; $display("[TB] FAIL mthi: got %h expected 00001234", hi); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if ({hi, lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin failures++; $display("[TB] FAIL mthi_mtlo_both: got %h_%h expected cafef00d_cafef00d", hi, lo); end
    runOp(2'b01, 32'd3, 32'd5, e);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if ({hi, lo} !== {32'd0, 32'd15}) begin failures++; $display("[TB] FAIL write_in_done: got %h_%h expected 00000000_0000000f", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int e;
    bit sawDone;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("[TB] FAIL rst_mid_hilo: got %h_%h expected 0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    sawDone = 0;
    repeat (40) begin @(negedge clk); if (done) sawDone = 1; end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_nodone: got done pulse expected none"); end
    runOp(2'b01, 32'd6, 32'd7, e);
    checks++; if (e !== 34) begin failures++; $display("[TB] FAIL post_rst_latency: got %0d expected 34", e); end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin failures++; $display("[TB] FAIL post_rst_result: got %h_%h expected 00000000_0000002a", hi, lo); end
  endtask

  initial begin
    start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    $display("[TB] starting muldiv_unit tests");
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_latch_and_ignore();
    test_writes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
